sw_debouncer: RTL
=================

# sw_debouncer

Per-bit synchronizer and debouncer for the ten board slide switches, sitting directly upstream of the muxer stage. It takes the raw asynchronous switch bank, runs each bit through a two-flop synchronizer and a stability counter, and presents a clean registered `sw_out` vector that drives the muxer's `SW` input. It also emits one-cycle rise/fall pulses per bit for downstream control logic.

## Interface

Parameters:

- `WIDTH`, 10, number of switch bits.
- `STABLE_CYCLES`, 500000, consecutive synchronized cycles a new level must hold before it is accepted (10 ms at 50 MHz). Legal range: 1 or greater.

Ports:

- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sw_in`  input  WIDTH  raw switch levels, asynchronous to `clk`.
- `sw_out`  output  WIDTH  debounced, registered switch levels; connects to muxer `SW`.
- `sw_rise`  output  WIDTH  one-cycle pulse per bit when `sw_out[i]` goes 0→1.
- `sw_fall`  output  WIDTH  one-cycle pulse per bit when `sw_out[i]` goes 1→0.
- `sw_changed`  output  1  OR of all `sw_rise | sw_fall` bits, registered in the same cycle.

## Operation

- Reset (`rst_n` low, asynchronous): both synchronizer stages, all counters, `sw_out`, `sw_rise`, `sw_fall` and `sw_changed` clear to 0 immediately, with no clock edge required. Release is sampled on the next rising edge.
- Synchronizer: `sync1 <= sw_in`, `sync2 <= sync1`. Only `sync2` is used downstream.
- Per bit i, each cycle:
  - If `sync2[i] == sw_out[i]`, then `cnt[i] <= 0`. This is the idle state.
  - Otherwise, if `cnt[i] == STABLE_CYCLES-1`, then `sw_out[i] <= sync2[i]` and `cnt[i] <= 0`, and the matching rise or fall bit asserts. This is the accept state.
  - Otherwise `cnt[i] <= cnt[i]+1`. This is the counting state.
- Bounce rule: any cycle in which `sync2[i]` returns to `sw_out[i]` resets `cnt[i]` to 0. Partial counts are never retained.
- Counter width is `$clog2(STABLE_CYCLES)`, with a minimum of 1 bit. The counter never wraps, because the accept branch always reloads it to 0.
- Bits are fully independent. Simultaneous changes on several bits each debounce on their own counter. Several pulses may assert in the same cycle, and `sw_changed` is then a single 1.
- `sw_rise`, `sw_fall` and `sw_changed` default to 0 every cycle in which no accept occurs.
- `STABLE_CYCLES = 1`: a bit is accepted on the first edge at which `sync2` differs from `sw_out`, which makes the block a pure synchronizer.
- After reset, if switches are already high, `sw_out` still starts at 0. Those bits debounce normally and produce `sw_rise` pulses. This is the required behaviour.

## Timing

- Latency: suppose a raw level change becomes stable before rising edge E0. It is captured in `sync1` at E0 and in `sync2` at E1. `sw_out` and the pulse then update at edge E1+`STABLE_CYCLES`, for a total of `STABLE_CYCLES`+2 edges including the E0 capture.
- Pulses are registered in the same edge as the `sw_out` update and last exactly one cycle.
- Outputs are all registered, so there is no combinational path from `sw_in` to any output.
- Reset asserted mid-count discards progress. After release, counting restarts from 0 against `sw_out = 0`.

## Test plan

Run with `STABLE_CYCLES = 4` and `WIDTH = 10`.

1. **Reset values:** hold `rst_n` low with `sw_in = 10'h3FF` → `sw_out = 0` and all pulses are 0. Then release → `sw_out = 10'h3FF` exactly 6 edges after release, and `sw_rise = 10'h3FF` with `sw_changed = 1` for that one cycle only.
2. **Clean edge:** from `sw_out = 0`, set `sw_in[3:0] = 4'b1100` stable → `sw_out[3:0] = 4'b1100` on the 6th edge, `sw_rise = 10'h00C` for one cycle, and `sw_fall = 0`.
3. **Bounce rejection:** toggle `sw_in[8]` 1,0,1,0,1 with 3-cycle segments, then hold at 1 → `sw_out[8]` stays 0 through the bounce. It goes 1 only 6 edges after the final stable 1, with exactly one `sw_rise[8]` pulse.
4. **Glitch:** drive a 1-cycle high pulse on `sw_in[5]` → `sw_out[5]` never changes, and `sw_changed` stays 0.
5. **Simultaneous changes:** with `sw_out = 10'h0F0`, set `sw_in = 10'h10F` → on a single edge `sw_out = 10'h10F`, `sw_rise = 10'h10F`, `sw_fall = 10'h0F0`, and `sw_changed = 1`.
6. **Reset mid-count:** start a 1→0 change on bit 9 and assert `rst_n` low after 2 counted cycles → all outputs are 0 asynchronously. After release, with `sw_in[9] = 0`, no `sw_fall` pulse occurs.

Source files
------------

// File: rtl/sw_debouncer.sv
// sw_debouncer
//
// Synchronizes and debounces a bank of slide switches. Each bit passes
// through a two-flop synchronizer and then a stability counter. A new level
// must hold for STABLE_CYCLES consecutive synchronized cycles before it
// reaches sw_out. Accepted changes also produce one-cycle rise/fall pulses.
//
// Parameters
//   WIDTH          number of switch bits
//   STABLE_CYCLES  cycles a new level must hold before it is accepted (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sw_in       raw switch levels, asynchronous to clk
//   sw_out      debounced, registered switch levels
//   sw_rise     one-cycle pulse per bit on an accepted 0->1
//   sw_fall     one-cycle pulse per bit on an accepted 1->0
//   sw_changed  OR of all rise/fall pulses, same cycle

module sw_debouncer #(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  // $clog2(1) is 0, so force at least one counter bit.
  localparam int              CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q,   sync1_d;
  logic [WIDTH-1:0] sync2_q,   sync2_d;
  logic [WIDTH-1:0] sw_out_q,  sw_out_d;
  logic [WIDTH-1:0] sw_rise_q, sw_rise_d;
  logic [WIDTH-1:0] sw_fall_q, sw_fall_d;
  logic             sw_changed_q, sw_changed_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  always_comb begin
    sync1_d   = sw_in;
    sync2_d   = sync1_q;
    sw_out_d  = sw_out_q;
    sw_rise_d = '0;
    sw_fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Any cycle matching the current output discards partial progress.
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_out_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          sw_out_d[i]  = sync2_q[i];
          sw_rise_d[i] = sync2_q[i];
          sw_fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    sw_changed_d = |(sw_rise_d | sw_fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sw_out_q     <= '0;
      sw_rise_q    <= '0;
      sw_fall_q    <= '0;
      sw_changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sw_out_q     <= sw_out_d;
      sw_rise_q    <= sw_rise_d;
      sw_fall_q    <= sw_fall_d;
      sw_changed_q <= sw_changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_out     = sw_out_q;
  assign sw_rise    = sw_rise_q;
  assign sw_fall    = sw_fall_q;
  assign sw_changed = sw_changed_q;

endmodule
